// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one word per frame from a FWFT FIFO
// and shifts it out as start, data (LSB first), optional parity, stop.
module uart_tx_serializer #(
  parameter int FIFO_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (FIFO_WIDTH > 2) ? $clog2(FIFO_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(FIFO_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FIFO_WIDTH-1:0]   shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pop;
  logic                    can_load;
  logic                    baud_end;

  // Reset blocks the pop so an aborted cycle never consumes a word.
  assign can_load = tx_en & ~fifo_empty & ~rst;
  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;
    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        pop = can_load;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            pop     = can_load;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A pop always restarts the frame with a fresh baud phase.
    if (pop) begin
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = fifo_rd_data;
      parity_d = (^fifo_rd_data) ^ (PARITY_ODD != 0);
    end
  end

  // Outputs are decoded from next state so the registered line
  // shows the start bit on the cycle right after the pop.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP: begin
        tx_d   = 1'b1;
        done_d = (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
      end
      default:  tx_d = 1'b1;
    endcase
  end

  assign fifo_rd_en = pop;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: table vectors, corner sequences and
// random back-to-back frames against a frame-level line model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int FL  = (1 + 8 + 1) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en, tx, busy, tx_done;

  logic       x_empty = 1'b1;
  logic [7:0] x_data = 8'h07;
  logic [7:0] x3_data = 8'h3C;
  logic [2:0] x_rd, x_tx, x_busy, x_done;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .FIFO_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
    .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(
    .FIFO_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) u_pe (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(x_empty),
    .fifo_rd_data(x_data), .fifo_rd_en(x_rd[0]),
    .tx(x_tx[0]), .busy(x_busy[0]), .tx_done(x_done[0])
  );

  uart_tx_serializer #(
    .FIFO_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1),
    .PARITY_EN(1), .PARITY_ODD(1)
  ) u_po (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(x_empty),
    .fifo_rd_data(x_data), .fifo_rd_en(x_rd[1]),
    .tx(x_tx[1]), .busy(x_busy[1]), .tx_done(x_done[1])
  );

  uart_tx_serializer #(
    .FIFO_WIDTH(8), .CLKS_PER_BIT(16), .STOP_BITS(2),
    .PARITY_EN(0), .PARITY_ODD(0)
  ) u_s2 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(x_empty),
    .fifo_rd_data(x3_data), .fifo_rd_en(x_rd[2]),
    .tx(x_tx[2]), .busy(x_busy[2]), .tx_done(x_done[2])
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // FWFT FIFO model feeding the main DUT
  logic [7:0] fq[$];
  logic [7:0] mw[$];
  logic       pop_pend = 1'b0;

  always @(negedge clk) begin
    #2;
    pop_pend = fifo_rd_en;
    if (fifo_rd_en) chk("pop_nonempty", {31'b0, fifo_empty}, 0);
  end

  always @(posedge clk) begin
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    fifo_empty   <= (fq.size() == 0);
    fifo_rd_data <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  logic cap_tx   [0:255];
  logic cap_done [0:255];
  logic cap_busy [0:255];
  logic cap_pop  [0:255];

  task automatic record(input int k);
    cap_tx[k]   = tx;
    cap_done[k] = tx_done;
    cap_busy[k] = busy;
    cap_pop[k]  = fifo_rd_en;
  endtask

  // Waits for a pop, then records cycles 0..ncyc relative to it.
  task automatic capture(input int ncyc, input int drop_k, input int rst_k);
    int w;
    for (w = 0; w < 300; w++) begin
      #1;
      if (fifo_rd_en) break;
      @(negedge clk);
    end
    chk("pop_seen", {31'b0, w < 300}, 1);
    record(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      #1;
      record(k);
      if (k == drop_k) tx_en = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (rst_k >= 0 && k == rst_k + 1) rst = 1'b0;
    end
  endtask

  // Expected line level k cycles after the first pop of words mw.
  function automatic logic model_tx(input int k);
    int f, pos;
    logic [7:0] w;
    if (k < 1) return 1'b1;
    f = (k - 1) / FL;
    if (f >= mw.size()) return 1'b1;
    pos = ((k - 1) % FL) / CPB;
    w = mw[f];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return w[pos-1];
    return 1'b1;
  endfunction

  function automatic int frame_errs(input int lo, input int hi);
    int e = 0;
    for (int k = lo; k <= hi; k++)
      if (cap_tx[k] !== model_tx(k)) e++;
    return e;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 0; k <= n; k++) if (cap_done[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_pops(input int n);
    int c = 0;
    for (int k = 0; k <= n; k++) if (cap_pop[k] === 1'b1) c++;
    return c;
  endfunction

  typedef struct {
    logic [7:0] word;
    logic [9:0] bits;
  } vec_t;

  vec_t tbl[6];

  logic [2:0] xt [0:200];
  logic [2:0] xd [0:200];
  logic [2:0] xb [0:200];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [9:0] act;
    logic [7:0] rb;
    int n, lows, fd0, fd1, fd2, hi_cnt;

    tbl[0] = '{8'hA5, 10'b0101001011};
    tbl[1] = '{8'h00, 10'b0000000001};
    tbl[2] = '{8'hFF, 10'b0111111111};
    tbl[3] = '{8'h3C, 10'b0001111001};
    tbl[4] = '{8'h01, 10'b0100000001};
    tbl[5] = '{8'h80, 10'b0000000011};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, tx_done}, 0);
    chk("rst_rd_en", {31'b0, fifo_rd_en}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fq.push_back(tbl[i].word);
      tx_en = 1'b1;
      capture(41, -1, -1);
      for (int b = 0; b < 10; b++) act[9-b] = cap_tx[1 + CPB*b + 2];
      chk("tbl_bits", {22'b0, act}, {22'b0, tbl[i].bits});
      mw.delete();
      mw.push_back(tbl[i].word);
      chk("tbl_wave", frame_errs(1, 41), 0);
      chk("tbl_done_at", first_done(41), 40);
      chk("tbl_pops", count_pops(41), 1);
      chk("tbl_busy", {30'b0, cap_busy[1], cap_busy[40]}, 3);
      chk("tbl_idle", {30'b0, cap_busy[41], cap_tx[41]}, 1);
    end

    mw.delete();
    mw.push_back(8'h00);
    mw.push_back(8'hFF);
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    capture(81, -1, -1);
    chk("b2b_wave", frame_errs(1, 81), 0);
    chk("b2b_pops", count_pops(81), 2);
    chk("b2b_pop2_at", {31'b0, cap_pop[40]}, 1);
    chk("b2b_gap", {30'b0, cap_tx[40], cap_tx[41]}, 2);
    n = 0;
    for (int k = 1; k <= 80; k++) if (cap_busy[k] === 1'b1) n++;
    chk("b2b_busy", n, 80);

    n = 0;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en) n++;
      if (!tx) lows++;
    end
    chk("empty_pops", n, 0);
    chk("empty_tx_low", lows, 0);

    tx_en = 1'b0;
    fq.push_back(8'h5A);
    n = 0;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en) n++;
      if (!tx) lows++;
    end
    chk("dis_pops", n, 0);
    chk("dis_tx_low", lows, 0);

    fq.push_back(8'h96);
    mw.delete();
    mw.push_back(8'h5A);
    tx_en = 1'b1;
    capture(100, 17, -1);
    chk("drop_pops", count_pops(100), 1);
    chk("drop_wave", frame_errs(1, 100), 0);
    chk("drop_done_at", first_done(100), 40);

    fq.push_back(8'hC3);
    mw.delete();
    mw.push_back(8'h96);
    tx_en = 1'b1;
    capture(15, -1, 14);
    chk("pre_rst_wave", frame_errs(1, 14), 0);
    chk("rst_mid_tx", {31'b0, cap_tx[15]}, 1);
    chk("rst_mid_busy", {31'b0, cap_busy[15]}, 0);
    chk("rst_mid_done", {31'b0, cap_done[15]}, 0);
    chk("rst_mid_pop", {31'b0, cap_pop[15]}, 0);
    mw.delete();
    mw.push_back(8'hC3);
    capture(41, -1, -1);
    chk("post_rst_wave", frame_errs(1, 41), 0);
    chk("post_rst_done", first_done(41), 40);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(2, 5);
      mw.delete();
      for (int j = 0; j < n; j++) begin
        rb = 8'($urandom);
        mw.push_back(rb);
        fq.push_back(rb);
      end
      capture(n * FL + 2, -1, -1);
      chk("rnd_wave", frame_errs(1, n * FL + 2), 0);
      chk("rnd_pops", count_pops(n * FL + 2), n);
      lows = 0;
      for (int k = 0; k <= n * FL + 2; k++) if (cap_done[k] === 1'b1) lows++;
      chk("rnd_dones", lows, n);
    end

    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    tx_en = 1'b1;
    x_empty = 1'b0;
    #1;
    chk("x_pop", {29'b0, x_rd}, 7);
    for (int k = 1; k <= 180; k++) begin
      @(negedge clk);
      if (k == 1) x_empty = 1'b1;
      #1;
      xt[k] = x_tx;
      xd[k] = x_done;
      xb[k] = x_busy;
    end
    chk("par_even_bit", {31'b0, xt[38][0]}, 1);
    chk("par_odd_bit", {31'b0, xt[38][1]}, 0);
    chk("par_stop", {30'b0, xt[42][1:0]}, 3);
    fd0 = -1;
    fd1 = -1;
    fd2 = -1;
    for (int k = 180; k >= 1; k--) begin
      if (xd[k][0]) fd0 = k;
      if (xd[k][1]) fd1 = k;
      if (xd[k][2]) fd2 = k;
    end
    chk("par_even_done", fd0, 44);
    chk("par_odd_done", fd1, 44);
    chk("par_idle_busy", {30'b0, xb[45][1:0]}, 0);
    for (int b = 0; b < 8; b++) rb[b] = xt[1 + 16 + 16*b + 8][2];
    chk("s2_data", {24'b0, rb}, 32'h3C);
    hi_cnt = 0;
    for (int k = 145; k <= 176; k++) if (xt[k][2]) hi_cnt++;
    chk("s2_stop_len", hi_cnt, 32);
    chk("s2_last_data", {31'b0, xt[144][2]}, 0);
    chk("s2_done_at", fd2, 176);
    chk("s2_idle_busy", {31'b0, xb[177][2]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
